vc_credit_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/credit link between `REQ_NUM` valid/ready requesters. It sits upstream of `vc_vr_converter` and drives that block's `s_data_i`/`s_valid_i`. It consumes the returned `s_credit_o` pulses. It tracks sender-side credits so the converter's `CREDIT_NUM`-deep buffer can never overflow. It issues at most one beat per cycle and grants fairly among active requesters.

---
 rtl/vc_pkg.sv | 19 +
 rtl/vc_credit_arbiter_if.sv | 29 ++
 rtl/vc_rr_arbiter.sv | 35 +++
 rtl/vc_credit_arbiter.sv | 87 ++++++++
 tb/tb_vc_credit_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/vc_pkg.sv
// Shared parameters and width helpers for the valid/credit link blocks
// (vc_credit_arbiter and vc_vr_converter).
package vc_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int CREDIT_NUM = 2;
    localparam int REQ_NUM    = 4;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int credit_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int req_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vc_credit_arbiter_if.sv
// Requester-side valid/ready bundle plus the credit link and status signals of
// the credit arbiter. The master modport is the arbiter's view.
interface vc_credit_arbiter_if
    import vc_pkg::*;
#(
    parameter int DW = vc_pkg::DATA_WIDTH,
    parameter int CN = vc_pkg::CREDIT_NUM,
    parameter int RN = vc_pkg::REQ_NUM
);
    logic [RN*DW-1:0]         s_data;
    logic [RN-1:0]            s_valid;
    logic [RN-1:0]            s_ready;
    logic [DW-1:0]            m_data;
    logic                     m_valid;
    logic                     m_credit;
    logic [credit_w(CN)-1:0]  credit_cnt;
    logic [req_w(RN)-1:0]     grant_id;
    logic                     err;

    modport master (
        input  s_data, s_valid, m_credit,
        output s_ready, m_data, m_valid, credit_cnt, grant_id, err
    );

    modport slave (
        output s_data, s_valid, m_credit,
        input  s_ready, m_data, m_valid, credit_cnt, grant_id, err
    );
endinterface

// File: rtl/vc_rr_arbiter.sv
// Combinational round-robin picker: first active request found from ptr+1
// upward, wrapping. The pointer register belongs to the caller.
module vc_rr_arbiter
    import vc_pkg::*;
#(
    parameter  int REQ_NUM = 4,
    localparam int REQ_W   = req_w(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [REQ_W-1:0]   ptr,
    input  logic               en,
    output logic [REQ_NUM-1:0] gnt,
    output logic [REQ_W-1:0]   gnt_idx
);
    logic [REQ_W-1:0] cand [REQ_NUM];

    // cand[k] is the requester examined at search position k (priority order).
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_cand
        assign cand[gi] = REQ_W'((32'(ptr) + 32'(gi + 1)) % 32'(REQ_NUM));
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = ptr;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (en && !found && req[cand[k]]) begin
                found         = 1'b1;
                gnt[cand[k]]  = 1'b1;
                gnt_idx       = cand[k];
            end
        end
    end
endmodule

// File: rtl/vc_credit_arbiter.sv
// Shares one valid/credit link among REQ_NUM valid/ready requesters with
// round-robin fairness and sender-side credit tracking.
module vc_credit_arbiter
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH = vc_pkg::DATA_WIDTH,
    parameter int CREDIT_NUM = vc_pkg::CREDIT_NUM,
    parameter int REQ_NUM    = vc_pkg::REQ_NUM
) (
    input logic               clk,
    input logic               rst_n,
    vc_credit_arbiter_if.master bus
);
    localparam int CW = credit_w(CREDIT_NUM);
    localparam int RW = req_w(REQ_NUM);

    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [RW-1:0]         ptr_reg;
    logic                  m_valid_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;
    logic                  err_reg;
    logic                  overflow;
    logic                  eligible;
    logic                  send;
    logic [REQ_NUM-1:0]    gnt;
    logic [RW-1:0]         gnt_idx;
    logic [DATA_WIDTH-1:0] slice [REQ_NUM];

    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_slice
        assign slice[gi] = bus.s_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Eligibility looks only at the registered count, so a returning credit
    // never reaches s_ready combinationally.
    assign eligible = (cnt_reg != '0);

    vc_rr_arbiter #(.REQ_NUM(REQ_NUM)) u_rr (
        .req     (bus.s_valid),
        .ptr     (ptr_reg),
        .en      (eligible),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign send = |gnt;

    always_comb begin
        cnt_next = cnt_reg;
        overflow = 1'b0;
        if (send && !bus.m_credit) begin
            cnt_next = cnt_reg - CW'(1);
        end else if (!send && bus.m_credit) begin
            if (cnt_reg == CW'(CREDIT_NUM)) begin
                overflow = 1'b1;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= CW'(CREDIT_NUM);
            ptr_reg     <= RW'(REQ_NUM - 1);
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            err_reg     <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            m_valid_reg <= send;
            if (send) begin
                ptr_reg    <= gnt_idx;
                m_data_reg <= slice[gnt_idx];
            end
            if (overflow) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.s_ready    = gnt;
    assign bus.m_data     = m_data_reg;
    assign bus.m_valid    = m_valid_reg;
    assign bus.credit_cnt = cnt_reg;
    assign bus.grant_id   = ptr_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_vc_credit_arbiter.sv
// Bench for vc_credit_arbiter: directed vector table, corner-case sequences,
// then random traffic against a behavioural model.
module tb_vc_credit_arbiter;
    localparam int DW = 8;
    localparam int CN = 2;
    localparam int RN = 4;

    logic clk_tb = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_tb = ~clk_tb;

    vc_credit_arbiter_if #(.DW(DW), .CN(CN), .RN(RN)) bus ();

    vc_credit_arbiter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN), .REQ_NUM(RN)) dut (
        .clk   (clk_tb),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [RN-1:0]    valid;
        logic [RN*DW-1:0] data;
        logic             credit;
        logic [RN-1:0]    ready;
        logic             mv;
        logic [DW-1:0]    md;
        int               cnt;
        int               grant;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [RN-1:0] v, input logic [RN*DW-1:0] d,
                                input logic c, input logic [RN-1:0] r, input logic mv,
                                input logic [DW-1:0] md, input int cnt, input int g);
        vec_t x;
        x.valid = v; x.data = d; x.credit = c; x.ready = r;
        x.mv = mv; x.md = md; x.cnt = cnt; x.grant = g;
        return x;
    endfunction

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.s_valid  = '0;
        bus.s_data   = '0;
        bus.m_credit = 1'b0;
        repeat (3) @(posedge clk_tb);
        @(negedge clk_tb);
        rst_n = 1'b1;
    endtask

    // Behavioural model state
    int m_cnt, m_ptr, m_err;
    logic m_mv;
    logic [DW-1:0] m_md;
    logic [RN-1:0] pend_v;
    logic [DW-1:0] pend_d [RN];

    function automatic int pick(input logic [RN-1:0] v, input int cnt, input int ptr);
        if (cnt == 0) return -1;
        for (int k = 1; k <= RN; k++) begin
            if (v[(ptr + k) % RN]) return (ptr + k) % RN;
        end
        return -1;
    endfunction

    initial begin
        // Round-robin from reset (every send credited back in the same cycle)
        vecs.push_back(mk(4'hF, 32'h13121110, 1, 4'b0001, 0, 8'h00, 2, 3));
        vecs.push_back(mk(4'hF, 32'h13121110, 1, 4'b0010, 1, 8'h10, 2, 0));
        vecs.push_back(mk(4'hF, 32'h13121110, 1, 4'b0100, 1, 8'h11, 2, 1));
        vecs.push_back(mk(4'hF, 32'h13121110, 1, 4'b1000, 1, 8'h12, 2, 2));
        vecs.push_back(mk(4'hF, 32'h13121110, 1, 4'b0001, 1, 8'h13, 2, 3));
        vecs.push_back(mk(4'h0, 32'h0,        0, 4'b0000, 1, 8'h10, 2, 0));
        // Credit exhaustion: AA, BB, then CC stalls until a credit returns
        vecs.push_back(mk(4'h1, 32'hAA, 0, 4'b0001, 0, 8'h10, 2, 0));
        vecs.push_back(mk(4'h1, 32'hBB, 0, 4'b0001, 1, 8'hAA, 1, 0));
        vecs.push_back(mk(4'h1, 32'hCC, 0, 4'b0000, 1, 8'hBB, 0, 0));
        vecs.push_back(mk(4'h1, 32'hCC, 1, 4'b0000, 0, 8'hBB, 0, 0));
        vecs.push_back(mk(4'h1, 32'hCC, 0, 4'b0001, 0, 8'hBB, 1, 0));
        vecs.push_back(mk(4'h0, 32'h0,  0, 4'b0000, 1, 8'hCC, 0, 0));
        // Send coinciding with a credit at cnt=1, next beat without gap
        vecs.push_back(mk(4'h0, 32'h0,    1, 4'b0000, 0, 8'hCC, 0, 0));
        vecs.push_back(mk(4'h2, 32'h5500, 1, 4'b0010, 0, 8'hCC, 1, 0));
        vecs.push_back(mk(4'h2, 32'h6600, 0, 4'b0010, 1, 8'h55, 1, 1));
        vecs.push_back(mk(4'h0, 32'h0,    1, 4'b0000, 1, 8'h66, 0, 1));
        vecs.push_back(mk(4'h0, 32'h0,    1, 4'b0000, 0, 8'h66, 1, 1));
        vecs.push_back(mk(4'h0, 32'h0,    0, 4'b0000, 0, 8'h66, 2, 1));

        do_reset();
        chk("reset_cnt",   32'(bus.credit_cnt), 32'd2);
        chk("reset_valid", 32'(bus.m_valid),    32'd0);
        chk("reset_data",  32'(bus.m_data),     32'd0);
        chk("reset_grant", 32'(bus.grant_id),   32'd3);
        chk("reset_err",   32'(bus.err),        32'd0);

        foreach (vecs[i]) begin
            @(posedge clk_tb); #1;
            bus.s_valid  = vecs[i].valid;
            bus.s_data   = vecs[i].data;
            bus.m_credit = vecs[i].credit;
            #1;
            $display("row %0d valid=%b credit=%0d ready=%b m_valid=%0d m_data=%h cnt=%0d grant=%0d",
                     i, vecs[i].valid, vecs[i].credit, bus.s_ready, bus.m_valid,
                     bus.m_data, bus.credit_cnt, bus.grant_id);
            chk($sformatf("row%0d_ready", i), 32'(bus.s_ready),    32'(vecs[i].ready));
            chk($sformatf("row%0d_mvalid", i), 32'(bus.m_valid),   32'(vecs[i].mv));
            chk($sformatf("row%0d_mdata", i), 32'(bus.m_data),     32'(vecs[i].md));
            chk($sformatf("row%0d_cnt", i),   32'(bus.credit_cnt), 32'(vecs[i].cnt));
            chk($sformatf("row%0d_grant", i), 32'(bus.grant_id),   32'(vecs[i].grant));
            chk($sformatf("row%0d_err", i),   32'(bus.err),        32'd0);
        end

        // Overflow: credit at full count with no send
        @(posedge clk_tb); #1;
        bus.s_valid = '0; bus.m_credit = 1'b1;
        @(posedge clk_tb); #1;
        bus.m_credit = 1'b0;
        #1;
        $display("overflow cnt=%0d err=%0d", bus.credit_cnt, bus.err);
        chk("ovf_cnt", 32'(bus.credit_cnt), 32'd2);
        chk("ovf_err", 32'(bus.err),        32'd1);
        repeat (3) @(posedge clk_tb);
        #1;
        chk("ovf_err_sticky", 32'(bus.err), 32'd1);

        // Mid-beat reset with m_valid high and no credits left
        @(posedge clk_tb); #1;
        bus.s_valid = 4'h1; bus.s_data = 32'h77;
        @(posedge clk_tb); #1;
        bus.s_data = 32'h88;
        @(posedge clk_tb); #1;
        bus.s_valid = '0;
        #1;
        chk("pre_rst_valid", 32'(bus.m_valid),    32'd1);
        chk("pre_rst_cnt",   32'(bus.credit_cnt), 32'd0);
        chk("pre_rst_data",  32'(bus.m_data),     32'h88);
        rst_n = 1'b0;
        #1;
        $display("async reset m_valid=%0d cnt=%0d err=%0d", bus.m_valid, bus.credit_cnt, bus.err);
        chk("rst_valid", 32'(bus.m_valid),    32'd0);
        chk("rst_cnt",   32'(bus.credit_cnt), 32'd2);
        chk("rst_err",   32'(bus.err),        32'd0);
        chk("rst_grant", 32'(bus.grant_id),   32'd3);

        // Random traffic against the model
        do_reset();
        m_cnt = CN; m_ptr = RN - 1; m_err = 0; m_mv = 1'b0; m_md = '0;
        pend_v = '0;
        for (int i = 0; i < RN; i++) pend_d[i] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int w;
            logic cr;
            logic [RN-1:0] exp_rdy;
            @(posedge clk_tb); #1;
            for (int i = 0; i < RN; i++) begin
                if (!pend_v[i] && ($urandom_range(2) == 0)) begin
                    pend_v[i] = 1'b1;
                    pend_d[i] = DW'($urandom);
                end
            end
            if (m_cnt < CN) cr = ($urandom_range(1) == 1);
            else            cr = ($urandom_range(39) == 0);
            bus.s_valid  = pend_v;
            for (int i = 0; i < RN; i++) bus.s_data[i*DW +: DW] = pend_d[i];
            bus.m_credit = cr;
            #1;
            w = pick(pend_v, m_cnt, m_ptr);
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("rnd_ready",  32'(bus.s_ready),    32'(exp_rdy));
            chk("rnd_mvalid", 32'(bus.m_valid),    32'(m_mv));
            chk("rnd_mdata",  32'(bus.m_data),     32'(m_md));
            chk("rnd_cnt",    32'(bus.credit_cnt), 32'(m_cnt));
            chk("rnd_grant",  32'(bus.grant_id),   32'(m_ptr));
            chk("rnd_err",    32'(bus.err),        32'(m_err));
            if (w >= 0) begin
                $display("rnd %0d grant=%0d data=%h cnt=%0d", cyc, w, pend_d[w], m_cnt);
                m_mv  = 1'b1;
                m_md  = pend_d[w];
                m_ptr = w;
                pend_v[w] = 1'b0;
            end else begin
                m_mv = 1'b0;
            end
            m_cnt = m_cnt - ((w >= 0) ? 1 : 0) + (cr ? 1 : 0);
            if (m_cnt > CN) begin
                m_cnt = CN;
                m_err = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
